// File: rtl/tour_move_seq.sv
// Knight's Tour move sequencer: turns each one-hot L-move from the solution
// store into a vertical then a horizontal motion cmd, with rdy/clr handshake.
module tour_move_seq #(
  parameter int          NUM_MOVES = 24,
  parameter logic [3:0]  MV_OPC    = 4'h2,
  parameter logic [3:0]  FAN_OPC   = 4'h3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [4:0]  mv_indx,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        busy,
  output logic        tour_done,
  output logic        mv_err
);

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;
  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  typedef enum logic [1:0] {IDLE, CHK, WAIT_V, WAIT_H} state_t;

  state_t      state, state_nxt;
  logic [4:0]  mv_indx_nxt;
  logic [15:0] cmd_nxt, h_cmd, h_cmd_nxt;
  logic        cmd_rdy_nxt, tour_done_nxt, mv_err_nxt;
  logic        one_hot;
  logic [15:0] v_dec, h_dec;

  // Decode the one-hot move into both leg commands; anything else is illegal.
  always_comb begin
    one_hot = 1'b1;
    v_dec   = '0;
    h_dec   = '0;
    case (move)
      8'h01:   begin v_dec = {MV_OPC, HDG_N, 4'd2}; h_dec = {FAN_OPC, HDG_E, 4'd1}; end
      8'h02:   begin v_dec = {MV_OPC, HDG_N, 4'd2}; h_dec = {FAN_OPC, HDG_W, 4'd1}; end
      8'h04:   begin v_dec = {MV_OPC, HDG_N, 4'd1}; h_dec = {FAN_OPC, HDG_W, 4'd2}; end
      8'h08:   begin v_dec = {MV_OPC, HDG_S, 4'd1}; h_dec = {FAN_OPC, HDG_W, 4'd2}; end
      8'h10:   begin v_dec = {MV_OPC, HDG_S, 4'd2}; h_dec = {FAN_OPC, HDG_W, 4'd1}; end
      8'h20:   begin v_dec = {MV_OPC, HDG_S, 4'd2}; h_dec = {FAN_OPC, HDG_E, 4'd1}; end
      8'h40:   begin v_dec = {MV_OPC, HDG_S, 4'd1}; h_dec = {FAN_OPC, HDG_E, 4'd2}; end
      8'h80:   begin v_dec = {MV_OPC, HDG_N, 4'd1}; h_dec = {FAN_OPC, HDG_E, 4'd2}; end
      default: one_hot = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    mv_indx_nxt   = mv_indx;
    cmd_nxt       = cmd;
    h_cmd_nxt     = h_cmd;
    cmd_rdy_nxt   = cmd_rdy;
    tour_done_nxt = 1'b0;
    mv_err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start_tour) begin
          mv_indx_nxt = '0;
          state_nxt   = CHK;
        end
      end
      CHK: begin
        if (one_hot) begin
          cmd_nxt     = v_dec;
          h_cmd_nxt   = h_dec;
          cmd_rdy_nxt = 1'b1;
          state_nxt   = WAIT_V;
        end else begin
          mv_err_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      WAIT_V: begin
        // A leg-complete pulse only counts once the cmd has been consumed.
        if (send_resp && !cmd_rdy) begin
          cmd_nxt     = h_cmd;
          cmd_rdy_nxt = 1'b1;
          state_nxt   = WAIT_H;
        end else if (clr_cmd_rdy) begin
          cmd_rdy_nxt = 1'b0;
        end
      end
      WAIT_H: begin
        if (send_resp && !cmd_rdy) begin
          if (mv_indx == LAST_IDX) begin
            tour_done_nxt = 1'b1;
            state_nxt     = IDLE;
          end else begin
            mv_indx_nxt = mv_indx + 5'd1;
            state_nxt   = CHK;
          end
        end else if (clr_cmd_rdy) begin
          cmd_rdy_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mv_indx   <= '0;
      cmd       <= '0;
      h_cmd     <= '0;
      cmd_rdy   <= 1'b0;
      tour_done <= 1'b0;
      mv_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      mv_indx   <= mv_indx_nxt;
      cmd       <= cmd_nxt;
      h_cmd     <= h_cmd_nxt;
      cmd_rdy   <= cmd_rdy_nxt;
      tour_done <= tour_done_nxt;
      mv_err    <= mv_err_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tour_move_seq.sv
// Randomised bench for tour_move_seq: a leg-level reference model checked every
// cycle, a cmd_proc responder with random handshake timing, and literal pins.
module tb_tour_move_seq;

  localparam int NUM_MOVES = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [4:0]  mv_indx;
  logic [15:0] cmd;
  logic        cmd_rdy, busy, tour_done, mv_err;

  logic [7:0]  store [32];
  int          checks = 0;
  int          errors = 0;

  tour_move_seq #(.NUM_MOVES(NUM_MOVES), .MV_OPC(4'h2), .FAN_OPC(4'h3)) dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .move(move),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .mv_indx(mv_indx),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .busy(busy), .tour_done(tour_done), .mv_err(mv_err)
  );

  always #5 clk = ~clk;
  assign move = store[mv_indx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dx_of(input int k);
    case (k)
      0: return 1;  1: return -1; 2: return -2; 3: return -2;
      4: return -1; 5: return 1;  6: return 2;  default: return 2;
    endcase
  endfunction

  function automatic int dy_of(input int k);
    case (k)
      0: return 2;  1: return 2;  2: return 1;  3: return -1;
      4: return -2; 5: return -2; 6: return -1; default: return 1;
    endcase
  endfunction

  function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input bit horiz);
    int k, dx, dy;
    k = 0;
    for (int i = 0; i < 8; i++) if (mv[i]) k = i;
    dx = dx_of(k);
    dy = dy_of(k);
    if (!horiz) return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
    return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
  endfunction

  // Reference model: tracks the active move, which leg is outstanding and
  // whether a one-cycle validity check is pending.
  bit          m_valid = 1'b0;
  bit          m_active, m_chk, m_leg, m_rdy, m_done, m_err;
  logic [4:0]  m_idx;
  logic [15:0] m_cmd;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1; m_active <= 1'b0; m_chk <= 1'b0; m_leg <= 1'b0;
      m_idx <= '0; m_cmd <= '0; m_rdy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
    end else if (m_valid) begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (!m_active) begin
        if (start_tour) begin
          m_active <= 1'b1; m_chk <= 1'b1; m_idx <= '0; m_leg <= 1'b0;
        end
      end else if (m_chk) begin
        m_chk <= 1'b0;
        if ($countones(store[m_idx]) == 1) begin
          m_cmd <= leg_cmd(store[m_idx], 1'b0);
          m_rdy <= 1'b1;
        end else begin
          m_err <= 1'b1; m_active <= 1'b0;
        end
      end else if (send_resp && !m_rdy) begin
        if (!m_leg) begin
          m_leg <= 1'b1; m_cmd <= leg_cmd(store[m_idx], 1'b1); m_rdy <= 1'b1;
        end else if (int'(m_idx) == NUM_MOVES - 1) begin
          m_done <= 1'b1; m_active <= 1'b0;
        end else begin
          m_idx <= m_idx + 5'd1; m_leg <= 1'b0; m_chk <= 1'b1;
        end
      end else if (clr_cmd_rdy) begin
        m_rdy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid)
      chk("cycle_model", 32'({mv_indx, cmd, cmd_rdy, busy, tour_done, mv_err}),
          32'({m_idx, m_cmd, m_rdy, m_active, m_done, m_err}));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_leg();
    logic [15:0] held;
    held = cmd;
    if ($urandom_range(0, 3) == 0) begin
      send_resp = 1'b1; cyc(); send_resp = 1'b0;
      chk("resp_while_rdy", 32'({cmd_rdy, cmd}), 32'({1'b1, held}));
    end
    repeat ($urandom_range(0, 2)) cyc();
    clr_cmd_rdy = 1'b1;
    if ($urandom_range(0, 3) == 0) send_resp = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    chk("clr_drops_rdy", 32'({cmd_rdy, cmd}), 32'({1'b0, held}));
    repeat ($urandom_range(0, 3)) begin
      start_tour  = ($urandom_range(0, 4) == 0);
      clr_cmd_rdy = ($urandom_range(0, 4) == 0);
      cyc();
      start_tour  = 1'b0;
      clr_cmd_rdy = 1'b0;
    end
    send_resp = 1'b1; cyc(); send_resp = 1'b0;
  endtask

  int          r_legs, r_err_idx, r_done_idx;
  bit          r_done, r_err, r_busy_end, r_aborted;
  logic [15:0] cap [$];

  task automatic run_tour(input int abort_at);
    int cycles;
    bit fin;
    r_legs = 0; r_done = 0; r_err = 0; r_err_idx = -1; r_done_idx = -1;
    r_busy_end = 1; r_aborted = 0;
    cap.delete();
    start_tour = 1'b1; cyc(); start_tour = 1'b0;
    cycles = 0; fin = 0;
    while (!fin) begin
      if (mv_err) begin
        r_err = 1; r_err_idx = int'(mv_indx); r_busy_end = busy; fin = 1;
      end else if (tour_done) begin
        r_done = 1; r_done_idx = int'(mv_indx); r_busy_end = busy; fin = 1;
      end else if (cmd_rdy) begin
        chk("leg_index", 32'(mv_indx), 32'(r_legs / 2));
        cap.push_back(cmd);
        r_legs++;
        if (r_legs > 2 * NUM_MOVES) begin
          checks++; errors++;
          $display("FAIL leg_overrun actual=%0d required<=%0d", r_legs, 2 * NUM_MOVES);
          fin = 1;
        end else if (r_legs % 2 == 0 && int'(mv_indx) == abort_at) begin
          rst = 1'b1; cyc(); rst = 1'b0; r_aborted = 1; fin = 1;
        end else begin
          ack_leg();
        end
      end else begin
        cycles++;
        if (cycles > 5000) begin
          checks++; errors++;
          $display("FAIL run_timeout actual=%0d cycles required=event", cycles);
          fin = 1;
        end else cyc();
      end
    end
  endtask

  task automatic two_leg_lit(input string name, input logic [7:0] mv,
                             input logic [15:0] exp_v, input logic [15:0] exp_h);
    store[0] = mv;
    start_tour = 1'b1; cyc(); start_tour = 1'b0;
    chk({name, "_chk_rdy"}, 32'({cmd_rdy, busy}), 32'({1'b0, 1'b1}));
    cyc();
    chk({name, "_vcmd"}, 32'({cmd_rdy, busy, cmd}), 32'({1'b1, 1'b1, exp_v}));
    start_tour = 1'b1; cyc(); start_tour = 1'b0;
    chk({name, "_restart_ignored"}, 32'({mv_indx, cmd_rdy, cmd}), 32'({5'd0, 1'b1, exp_v}));
    clr_cmd_rdy = 1'b1; cyc(); clr_cmd_rdy = 1'b0;
    send_resp = 1'b1; cyc(); send_resp = 1'b0;
    chk({name, "_hcmd"}, 32'({cmd_rdy, cmd}), 32'({1'b1, exp_h}));
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic find_tour();
    int px [25], py [25], nxt [25], mk [25];
    bit vis [25];
    int d, k, nx, ny, iter;
    bit found;
    for (int i = 0; i < 25; i++) vis[i] = 0;
    px[0] = 0; py[0] = 0; vis[0] = 1; nxt[0] = 0; d = 0; iter = 0;
    nx = 0; ny = 0;
    while (d < NUM_MOVES) begin
      iter++;
      if (iter > 20000000 || d < 0) begin
        $display("FAIL tour_search actual=none required=tour");
        $fatal(1);
      end
      found = 0;
      while (nxt[d] < 8 && !found) begin
        k = nxt[d];
        nxt[d]++;
        nx = px[d] + dx_of(k);
        ny = py[d] + dy_of(k);
        if (nx >= 0 && nx < 5 && ny >= 0 && ny < 5 && !vis[ny * 5 + nx]) begin
          found = 1; mk[d] = k;
        end
      end
      if (found) begin
        d++; px[d] = nx; py[d] = ny; vis[ny * 5 + nx] = 1; nxt[d] = 0;
      end else begin
        vis[py[d] * 5 + px[d]] = 0; d--;
      end
    end
    for (int i = 0; i < 32; i++) store[i] = 8'h00;
    for (int i = 0; i < NUM_MOVES; i++) store[i] = 8'(1 << mk[i]);
  endtask

  task automatic watch_no_done(input string name);
    int n;
    n = 0;
    repeat (4) begin cyc(); if (tour_done) n++; end
    chk(name, 32'(n), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) store[i] = 8'h01;
    repeat (3) cyc();
    rst = 1'b0;
    chk("reset_state", 32'({mv_indx, cmd, cmd_rdy, busy, tour_done, mv_err}), 32'd0);

    two_leg_lit("mv01", 8'h01, 16'h2002, 16'h3BF1);
    two_leg_lit("mv08", 8'h08, 16'h27F1, 16'h33F2);
    chk("abort_idle", 32'({busy, cmd_rdy}), 32'd0);

    find_tour();
    run_tour(-1);
    chk("tour_done_seen", 32'({r_done, r_err}), 32'({1'b1, 1'b0}));
    chk("tour_legs", 32'(r_legs), 32'(2 * NUM_MOVES));
    chk("tour_done_idx", 32'(r_done_idx), 32'(NUM_MOVES - 1));
    chk("busy_with_done", 32'(r_busy_end), 32'd0);
    for (int i = 0; i < cap.size() && i < 2 * NUM_MOVES; i++)
      chk("tour_cmd_order", 32'(cap[i]), 32'(leg_cmd(store[i / 2], (i % 2) == 1)));
    watch_no_done("done_single_pulse");

    for (int i = 0; i < 5; i++) store[i] = 8'(1 << $urandom_range(0, 7));
    store[5] = 8'h03;
    run_tour(-1);
    chk("err_seen", 32'({r_err, r_done}), 32'({1'b1, 1'b0}));
    chk("err_idx", 32'(r_err_idx), 32'd5);
    chk("err_legs", 32'(r_legs), 32'd10);
    chk("err_idle", 32'({r_busy_end, cmd_rdy}), 32'd0);
    cyc();
    chk("err_pulse_one", 32'({mv_err, mv_indx}), 32'({1'b0, 5'd5}));

    find_tour();
    run_tour(10);
    chk("abort_taken", 32'(r_aborted), 32'd1);
    chk("abort_outputs", 32'({mv_indx, cmd, cmd_rdy, busy, tour_done}), 32'd0);
    watch_no_done("abort_no_done");

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 32; i++)
        store[i] = ($urandom_range(0, 39) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'(1 << $urandom_range(0, 7));
      run_tour(-1);
      chk("rand_ended", 32'({r_done ^ r_err, r_busy_end}), 32'({1'b1, 1'b0}));
      repeat (2) cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
